// File: rtl/ethernet_bus_responder_pkg.sv
// Shared register indices, state encodings and pointer helper for the DM9000-style bus responder.
package ethernet_bus_responder_pkg;

    localparam logic [7:0] ETH_IDX_TCR    = 8'h02;
    localparam logic [7:0] ETH_IDX_VID0   = 8'h28;
    localparam logic [7:0] ETH_IDX_VID1   = 8'h29;
    localparam logic [7:0] ETH_IDX_PID0   = 8'h2A;
    localparam logic [7:0] ETH_IDX_PID1   = 8'h2B;
    localparam logic [7:0] ETH_IDX_MRCMDX = 8'hF0;
    localparam logic [7:0] ETH_IDX_MRCMD  = 8'hF2;
    localparam logic [7:0] ETH_IDX_MRRL   = 8'hF4;
    localparam logic [7:0] ETH_IDX_MRRH   = 8'hF5;
    localparam logic [7:0] ETH_IDX_MWCMD  = 8'hF8;
    localparam logic [7:0] ETH_IDX_MWRL   = 8'hFA;
    localparam logic [7:0] ETH_IDX_MWRH   = 8'hFB;
    localparam logic [7:0] ETH_IDX_ISR    = 8'hFE;
    localparam logic [7:0] ETH_IDX_IMR    = 8'hFF;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_WR_COMMIT,
        RESP_RD_COMMIT
    } EthRespState_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } EthTxState_t;

    // Pointers are handled as 16-bit values split into a low and a high register byte.
    function automatic logic [15:0] merge_ptr_byte(input logic [15:0] ptr,
                                                   input logic        hi,
                                                   input logic [7:0]  b);
        return hi ? {b, ptr[7:0]} : {ptr[15:8], b};
    endfunction

endpackage

// File: rtl/eth_resp_strobe_sync.sv
// Rising-edge (strobe release) detector for one active-low bus strobe.
// With ETH_RESP_SYNC_EN defined the strobe first passes a 2-flop synchronizer.
module eth_resp_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe_n_i,
    output logic rise_o
);

`ifdef ETH_RESP_SYNC_EN
    logic [2:0] sync_q;

    // Idle level of the strobe is high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[1:0], strobe_n_i};
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
`else
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b1;
        else     prev_q <= strobe_n_i;
    end

    assign rise_o = strobe_n_i & ~prev_q;
`endif

endmodule

// File: rtl/ethernet_bus_responder.sv
// Target-side DM9000-style host bus model: index port, register file, packet buffer, tx timer.
// Define ETH_RESP_SYNC_EN to synchronize the strobes (adds 2 clk of commit latency).
module ethernet_bus_responder
    import ethernet_bus_responder_pkg::*;
#(
    parameter int          BUF_AW     = 10,
    parameter int          TX_LATENCY = 16,
    parameter logic [15:0] VID        = 16'h0A46,
    parameter logic [15:0] PID        = 16'h9000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic        cmd,
    input  logic [15:0] sd_in,
    output logic [15:0] sd_out,
    output logic        sd_oe,
    output logic        intr
);

    localparam int BUF_DEPTH = 1 << BUF_AW;
    typedef logic [BUF_AW-1:0] ptr_t;

    logic          wr_rise, rd_rise;
    EthRespState_t resp_state_q, resp_state_d;
    EthTxState_t   tx_state_q, tx_state_d;
    logic [15:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]    index_q, index_d;
    logic [7:0]    imr_q, imr_d;
    logic          isr_tx_q, isr_tx_d;
    logic          tcr_q, tcr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    logic [15:0]   hold_data_q;
    logic          hold_cmd_q, hold_rd_cmd_q;
    logic [15:0]   buf_mem [BUF_DEPTH];
    logic [15:0]   buf_rd_q;
    logic          buf_we;
    logic [15:0]   rd_word, sd_out_q;
    logic          intr_q;
    logic [7:0]    isr_word;
    logic [15:0]   rd_ptr_ext, wr_ptr_ext;

    assign isr_word   = {6'b0, isr_tx_q, 1'b0};
    assign rd_ptr_ext = 16'(rd_ptr_q);
    assign wr_ptr_ext = 16'(wr_ptr_q);

    eth_resp_strobe_sync u_wr_sync (
        .clk        (clk),
        .rst        (rst),
        .strobe_n_i (cs_n | iow_n),
        .rise_o     (wr_rise)
    );

    eth_resp_strobe_sync u_rd_sync (
        .clk        (clk),
        .rst        (rst),
        .strobe_n_i (cs_n | ior_n),
        .rise_o     (rd_rise)
    );

    // Capture follows the raw pins; the value present at strobe release is what gets committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q   <= '0;
            hold_cmd_q    <= 1'b0;
            hold_rd_cmd_q <= 1'b0;
        end else begin
            if (!cs_n && !iow_n) begin
                hold_data_q <= sd_in;
                hold_cmd_q  <= cmd;
            end
            if (!cs_n && !ior_n) begin
                hold_rd_cmd_q <= cmd;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        resp_state_d = resp_state_q;
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        index_d      = index_q;
        imr_d        = imr_q;
        isr_tx_d     = isr_tx_q;
        tcr_d        = tcr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        buf_we       = 1'b0;

        unique case (resp_state_q)
            RESP_IDLE: begin
                if (wr_rise)      resp_state_d = RESP_WR_COMMIT;
                else if (rd_rise) resp_state_d = RESP_RD_COMMIT;
            end
            RESP_WR_COMMIT: begin
                resp_state_d = RESP_IDLE;
                if (!hold_cmd_q) begin
                    index_d = hold_data_q[7:0];
                end else begin
                    case (index_q)
                        ETH_IDX_MWCMD: begin
                            buf_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + ptr_t'(1);
                        end
                        ETH_IDX_MWRL: wr_ptr_d = ptr_t'(merge_ptr_byte(wr_ptr_ext, 1'b0, hold_data_q[7:0]));
                        ETH_IDX_MWRH: wr_ptr_d = ptr_t'(merge_ptr_byte(wr_ptr_ext, 1'b1, hold_data_q[7:0]));
                        ETH_IDX_MRRL: rd_ptr_d = ptr_t'(merge_ptr_byte(rd_ptr_ext, 1'b0, hold_data_q[7:0]));
                        ETH_IDX_MRRH: rd_ptr_d = ptr_t'(merge_ptr_byte(rd_ptr_ext, 1'b1, hold_data_q[7:0]));
                        ETH_IDX_IMR:  imr_d    = hold_data_q[7:0];
                        ETH_IDX_ISR:  isr_tx_d = isr_tx_q & ~hold_data_q[1];
                        ETH_IDX_TCR: begin
                            if (tx_state_q == TX_IDLE && hold_data_q[0]) tcr_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RESP_RD_COMMIT: begin
                resp_state_d = RESP_IDLE;
                if (hold_rd_cmd_q && index_q == ETH_IDX_MRCMD) rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            default: resp_state_d = RESP_IDLE;
        endcase

        // Evaluated after the bus commit so tx-done overrides a same-cycle ISR clear.
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tcr_q) begin
                    tx_state_d = TX_BUSY;
                    tx_cnt_d   = 16'(TX_LATENCY - 1);
                end
            end
            TX_BUSY: begin
                if (tx_cnt_q == 16'd0) begin
                    isr_tx_d   = 1'b1;
                    tcr_d      = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_state_q <= RESP_IDLE;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            index_q      <= '0;
            imr_q        <= '0;
            isr_tx_q     <= 1'b0;
            tcr_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            sd_out_q     <= '0;
            intr_q       <= 1'b0;
        end else begin
            resp_state_q <= resp_state_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            index_q      <= index_d;
            imr_q        <= imr_d;
            isr_tx_q     <= isr_tx_d;
            tcr_q        <= tcr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sd_out_q     <= rd_word;
            intr_q       <= |(isr_word & imr_q);
        end
    end

    // NOTE: the packet buffer has no reset so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[wr_ptr_q] <= hold_data_q;
        buf_rd_q <= buf_mem[rd_ptr_q];
    end

    always_comb begin
        rd_word = '0;
        if (!cmd) begin
            rd_word = {8'h00, index_q};
        end else begin
            case (index_q)
                ETH_IDX_MRCMDX, ETH_IDX_MRCMD: rd_word = buf_rd_q;
                ETH_IDX_VID0: rd_word = {8'h00, VID[7:0]};
                ETH_IDX_VID1: rd_word = {8'h00, VID[15:8]};
                ETH_IDX_PID0: rd_word = {8'h00, PID[7:0]};
                ETH_IDX_PID1: rd_word = {8'h00, PID[15:8]};
                ETH_IDX_TCR:  rd_word = {15'b0, tcr_q};
                ETH_IDX_ISR:  rd_word = {8'h00, isr_word};
                ETH_IDX_IMR:  rd_word = {8'h00, imr_q};
                ETH_IDX_MRRL: rd_word = {8'h00, rd_ptr_ext[7:0]};
                ETH_IDX_MRRH: rd_word = {8'h00, rd_ptr_ext[15:8]};
                ETH_IDX_MWRL: rd_word = {8'h00, wr_ptr_ext[7:0]};
                ETH_IDX_MWRH: rd_word = {8'h00, wr_ptr_ext[15:8]};
                default:      rd_word = '0;
            endcase
        end
    end

    assign sd_oe  = ~cs_n & ~ior_n;
    assign sd_out = sd_out_q;
    assign intr   = intr_q;

endmodule

// File: tb/tb_ethernet_bus_responder.sv
// Scoreboard bench for ethernet_bus_responder: bus tasks push expectations, a monitor compares.
module tb_ethernet_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, ior_n, iow_n, cmd;
    logic [15:0] sd_in;
    logic [15:0] sd_out;
    logic        sd_oe;
    logic        intr;

    always #5 clk = ~clk;

    ethernet_bus_responder dut (
        .clk    (clk),
        .rst    (rst),
        .cs_n   (cs_n),
        .ior_n  (ior_n),
        .iow_n  (iow_n),
        .cmd    (cmd),
        .sd_in  (sd_in),
        .sd_out (sd_out),
        .sd_oe  (sd_oe),
        .intr   (intr)
    );

    typedef struct {
        string       name;
        logic [15:0] data;
        logic        chk_data;
        logic        oe;
        logic        chk_intr;
        logic        intr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_errors  = 0;
    logic rd_sample = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge whenever a sample point is flagged.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rd_sample) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard_underflow: sample with no expectation queued");
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_oe"}, 16'(sd_oe), 16'(mon_e.oe));
                    if (mon_e.chk_data) check(mon_e.name, sd_out, mon_e.data);
                    if (mon_e.chk_intr) check({mon_e.name, "_intr"}, 16'(intr), 16'(mon_e.intr));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string name, input logic [15:0] data, input logic chk_data,
                            input logic oe, input logic chk_intr, input logic exp_intr);
        exp_t e;
        e.name     = name;
        e.data     = data;
        e.chk_data = chk_data;
        e.oe       = oe;
        e.chk_intr = chk_intr;
        e.intr     = exp_intr;
        exp_q.push_back(e);
    endtask

    // All bus tasks start and end on a falling clock edge.
    task automatic bus_write(input logic c, input logic [15:0] d, input int hold = 3, input int idle = 6);
        cs_n  = 1'b0;
        iow_n = 1'b0;
        cmd   = c;
        sd_in = d;
        repeat (hold) @(negedge clk);
        iow_n = 1'b1;
        cs_n  = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic bus_read(input logic c, input string name, input logic [15:0] exp,
                            input logic chk_intr = 1'b0, input logic exp_intr = 1'b0);
        cs_n  = 1'b0;
        ior_n = 1'b0;
        cmd   = c;
        repeat (4) @(negedge clk);
        push_exp(name, exp, 1'b1, 1'b1, chk_intr, exp_intr);
        rd_sample = 1'b1;
        @(negedge clk);
        rd_sample = 1'b0;
        ior_n = 1'b1;
        cs_n  = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic idle_sample(input string name, input logic [15:0] exp, input logic chk_data,
                               input logic exp_intr);
        push_exp(name, exp, chk_data, 1'b0, 1'b1, exp_intr);
        rd_sample = 1'b1;
        @(negedge clk);
        rd_sample = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] idx, input logic [15:0] d);
        bus_write(1'b0, {8'h00, idx});
        bus_write(1'b1, d);
    endtask

    task automatic reg_read(input logic [7:0] idx, input string name, input logic [15:0] exp,
                            input logic chk_intr = 1'b0, input logic exp_intr = 1'b0);
        bus_write(1'b0, {8'h00, idx});
        bus_read(1'b1, name, exp, chk_intr, exp_intr);
    endtask

    task automatic wait_intr(input string name, input int budget);
        int i = 0;
        while (intr !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 16'(intr), 16'h0001);
    endtask

    initial begin
        logic seen_intr;
        rst   = 1'b1;
        cs_n  = 1'b1;
        ior_n = 1'b1;
        iow_n = 1'b1;
        cmd   = 1'b0;
        sd_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_sample("reset_state", 16'h0000, 1'b1, 1'b0);

        // ID registers through the index/data ports
        bus_write(1'b0, 16'h0028);
        bus_read(1'b1, "vid_lo", 16'h0046);
        idle_sample("oe_idle", 16'h0000, 1'b0, 1'b0);
        bus_write(1'b0, 16'h0029);
        bus_read(1'b1, "vid_hi", 16'h000A);
        bus_read(1'b0, "index_port", 16'h0029);
        reg_read(8'h2A, "pid_lo", 16'h0000);
        reg_read(8'h2B, "pid_hi", 16'h0090);

        // Buffer fill and drain
        reg_write(8'hFA, 16'h0000);
        reg_write(8'hFB, 16'h0000);
        bus_write(1'b0, 16'h00F8);
        bus_write(1'b1, 16'h1111);
        bus_write(1'b1, 16'h2222);
        bus_write(1'b1, 16'h3333);
        bus_write(1'b1, 16'h4444);
        reg_write(8'hF4, 16'h0000);
        reg_write(8'hF5, 16'h0000);
        bus_write(1'b0, 16'h00F2);
        bus_read(1'b1, "mrcmd_0", 16'h1111);
        bus_read(1'b1, "mrcmd_1", 16'h2222);
        bus_read(1'b1, "mrcmd_2", 16'h3333);
        bus_read(1'b1, "mrcmd_3", 16'h4444);
        reg_read(8'hF4, "rd_ptr_after_4", 16'h0004);
        reg_read(8'hFA, "wr_ptr_after_4", 16'h0004);

        // Prefetch read does not advance the pointer
        reg_write(8'hF4, 16'h0001);
        bus_write(1'b0, 16'h00F0);
        bus_read(1'b1, "mrcmdx_a", 16'h2222);
        bus_read(1'b1, "mrcmdx_b", 16'h2222);
        reg_read(8'hF4, "mrcmdx_no_inc", 16'h0001);

        // Pointer wrap at the top of the buffer
        reg_write(8'hFA, 16'h00FF);
        reg_write(8'hFB, 16'h0003);
        reg_read(8'hFB, "wr_ptr_hi", 16'h0003);
        bus_write(1'b0, 16'h00F8);
        bus_write(1'b1, 16'hAAAA);
        bus_write(1'b1, 16'hBBBB);
        reg_read(8'hFA, "wr_ptr_wrap_lo", 16'h0001);
        reg_read(8'hFB, "wr_ptr_wrap_hi", 16'h0000);
        reg_write(8'hF4, 16'h00FF);
        reg_write(8'hF5, 16'h0003);
        bus_write(1'b0, 16'h00F2);
        bus_read(1'b1, "buf_3ff", 16'hAAAA);
        bus_read(1'b1, "buf_000", 16'hBBBB);
        reg_read(8'hF4, "rd_ptr_wrap", 16'h0001);

        // Transmit timer, interrupt and write-1-to-clear
        reg_write(8'hFF, 16'h0002);
        reg_write(8'h02, 16'h0001);
        wait_intr("tx_done_intr", 60);
        reg_read(8'hFE, "isr_after_tx", 16'h0002, 1'b1, 1'b1);
        reg_read(8'h02, "tcr_after_tx", 16'h0000);
        reg_write(8'hFE, 16'h0002);
        idle_sample("intr_cleared", 16'h0000, 1'b0, 1'b0);
        reg_read(8'hFE, "isr_cleared", 16'h0000, 1'b1, 1'b0);

        // ISR clear lands on the same clock as tx done (TCR commit + TX_LATENCY + 1)
        bus_write(1'b0, 16'h0002);
        bus_write(1'b1, 16'h0001, 3, 2);
        bus_write(1'b0, 16'h00FE, 3, 2);
        bus_write(1'b1, 16'h0002, 10, 6);
        idle_sample("collide_intr", 16'h0000, 1'b0, 1'b1);
        reg_read(8'hFE, "collide_isr", 16'h0002, 1'b1, 1'b1);
        reg_write(8'hFE, 16'h0002);

        // Reset in the middle of a transmit
        reg_write(8'h02, 16'h0001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_sample("post_reset", 16'h0000, 1'b1, 1'b0);
        bus_read(1'b0, "post_reset_index", 16'h0000);
        reg_read(8'hFF, "post_reset_imr", 16'h0000);
        reg_read(8'hFE, "post_reset_isr", 16'h0000);
        reg_read(8'h02, "post_reset_tcr", 16'h0000);
        reg_read(8'hFA, "post_reset_wr_ptr", 16'h0000);
        reg_read(8'hF4, "post_reset_rd_ptr", 16'h0000);
        reg_write(8'hFF, 16'h0002);
        seen_intr = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen_intr = seen_intr | intr;
        end
        check("post_reset_no_intr", 16'(seen_intr), 16'h0000);
        reg_read(8'hFE, "post_reset_isr_late", 16'h0000, 1'b1, 1'b0);
        bus_write(1'b0, 16'h00F2);
        bus_read(1'b1, "post_reset_mrcmd", 16'hBBBB);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
